// File: rtl/code_defs_pkg.sv
// ---------------------------------------------------------------------------
// code_defs_pkg
// Shared widths and types for the 32-bit PCS receive datapath.
// Used by rx_gearbox_32b66b: word/header/block widths, the slip blanking
// length, count-width helpers and the gearbox phase enumeration.
// ---------------------------------------------------------------------------
package code_defs_pkg;

  localparam int GB_WORD_W     = 32;
  localparam int GB_HDR_W      = 2;
  localparam int GB_BLOCK_W    = 66;
  localparam int GB_SLIP_BLANK = 32;

  // Occupancy/availability counters reach at most 65, so 7 bits suffice.
  localparam int GB_CNT_W   = 7;
  // The blanking counter must hold GB_SLIP_BLANK.
  localparam int GB_BLANK_W = 6;
  // First half consumes header + 32 data bits.
  localparam int GB_HALF1_W = GB_WORD_W + GB_HDR_W;

  localparam logic [GB_CNT_W-1:0]   GB_WORD_CNT   = GB_CNT_W'(GB_WORD_W);
  localparam logic [GB_CNT_W-1:0]   GB_HALF1_CNT  = GB_CNT_W'(GB_HALF1_W);
  localparam logic [GB_BLANK_W-1:0] GB_BLANK_LOAD = GB_BLANK_W'(GB_SLIP_BLANK);

  typedef enum logic [0:0] {
    GB_FIRST  = 1'b0,
    GB_SECOND = 1'b1
  } gb_phase_t;

endpackage

// File: rtl/rx_gearbox_32b66b.sv
// ---------------------------------------------------------------------------
// rx_gearbox_32b66b
// Receive gearbox: turns the unframed 32-bit transceiver word stream into
// 64b/66b block halves (32 data bits + 2-bit sync header) and performs
// single-bit slips requested by the block-lock state machine.
//
// Ports:
//   i_clk     recovered RX clock, rising edge
//   i_reset   asynchronous active-high reset
//   i_data    raw 32-bit line word, bit 0 earliest, sampled every cycle
//   i_slip    slip request, one accepted cycle discards one bit
//   o_data    block half for the descrambler
//   o_header  sync header of the current block, held for both halves
//   o_valid   o_data/o_header valid this cycle
//   o_first   o_data is the first half (block bits 33:2)
//
// Build option: define RX_GEARBOX_SLIP_BLANK_EN to ignore i_slip for
// GB_SLIP_BLANK cycles after each accepted slip.
// ---------------------------------------------------------------------------
module rx_gearbox_32b66b
  import code_defs_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [GB_WORD_W-1:0] i_data,
  input  logic                 i_slip,
  output logic [GB_WORD_W-1:0] o_data,
  output logic [GB_HDR_W-1:0]  o_header,
  output logic                 o_valid,
  output logic                 o_first
);

  logic [GB_BLOCK_W-1:0] bit_buf_r;   // bit 0 is the oldest stored bit
  logic [GB_CNT_W-1:0]   cnt_r;
  gb_phase_t             phase_r;
  logic [GB_BLOCK_W-1:0] comb_s;
  logic [GB_CNT_W-1:0]   avail_s;
  logic                  slip_take_s;

  // Append the new word above the stored bits; an accepted slip drops the
  // oldest bit of the combined vector (i_data[0] when the buffer is empty).
  function automatic logic [GB_BLOCK_W-1:0] gb_combine(
    input logic [GB_BLOCK_W-1:0] held,
    input logic [GB_WORD_W-1:0]  word,
    input logic [GB_CNT_W-1:0]   fill,
    input logic                  drop
  );
    logic [GB_BLOCK_W-1:0] v;
    v = held | ({{(GB_BLOCK_W-GB_WORD_W){1'b0}}, word} << fill);
    return drop ? (v >> 1) : v;
  endfunction

`ifdef RX_GEARBOX_SLIP_BLANK_EN
  logic [GB_BLANK_W-1:0] blank_r;

  assign slip_take_s = i_slip & (blank_r == {GB_BLANK_W{1'b0}});

  // Blanking counter: loaded on an accepted slip, counts down to re-arm.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      blank_r <= {GB_BLANK_W{1'b0}};
    end else if (slip_take_s) begin
      blank_r <= GB_BLANK_LOAD;
    end else if (blank_r != {GB_BLANK_W{1'b0}}) begin
      blank_r <= blank_r - {{(GB_BLANK_W-1){1'b0}}, 1'b1};
    end else begin
      blank_r <= blank_r;
    end
  end
`else
  assign slip_take_s = i_slip;
`endif

  // Combined vector and number of usable bits this cycle.
  always_comb begin
    comb_s  = gb_combine(bit_buf_r, i_data, cnt_r, slip_take_s);
    avail_s = cnt_r + GB_WORD_CNT - {{(GB_CNT_W-1){1'b0}}, slip_take_s};
  end

  // Phase FSM: emit a half when enough bits are available, keep the rest.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bit_buf_r <= {GB_BLOCK_W{1'b0}};
      cnt_r     <= {GB_CNT_W{1'b0}};
      phase_r   <= GB_FIRST;
      o_data    <= {GB_WORD_W{1'b0}};
      o_header  <= {GB_HDR_W{1'b0}};
      o_valid   <= 1'b0;
      o_first   <= 1'b0;
    end else begin
      case (phase_r)
        GB_FIRST: begin
          if (avail_s >= GB_HALF1_CNT) begin
            o_header  <= comb_s[GB_HDR_W-1:0];
            o_data    <= comb_s[GB_HALF1_W-1:GB_HDR_W];
            o_first   <= 1'b1;
            o_valid   <= 1'b1;
            bit_buf_r <= comb_s >> GB_HALF1_W;
            cnt_r     <= avail_s - GB_HALF1_CNT;
            phase_r   <= GB_SECOND;
          end else begin
            o_valid   <= 1'b0;
            bit_buf_r <= comb_s;
            cnt_r     <= avail_s;
          end
        end
        GB_SECOND: begin
          if (avail_s >= GB_WORD_CNT) begin
            o_data    <= comb_s[GB_WORD_W-1:0];
            o_first   <= 1'b0;
            o_valid   <= 1'b1;
            bit_buf_r <= comb_s >> GB_WORD_W;
            cnt_r     <= avail_s - GB_WORD_CNT;
            phase_r   <= GB_FIRST;
          end else begin
            o_valid   <= 1'b0;
            bit_buf_r <= comb_s;
            cnt_r     <= avail_s;
          end
        end
        default: begin
          o_valid   <= 1'b0;
          bit_buf_r <= comb_s;
          cnt_r     <= avail_s;
          phase_r   <= GB_FIRST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_gearbox_32b66b.sv
// ---------------------------------------------------------------------------
// tb_rx_gearbox_32b66b
// Self-checking bench for rx_gearbox_32b66b. A bit queue serialises 66-bit
// blocks LSB first into 32-bit words; expected halves are queued as blocks
// are serialised and compared as the DUT emits them. Slip scenarios
// resynchronise on an indexed block pattern and then check the stream.
// Honours RX_GEARBOX_SLIP_BLANK_EN for the held-slip expectation.
// ---------------------------------------------------------------------------
module tb_rx_gearbox_32b66b;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        slip;
  logic [31:0] dout;
  logic [1:0]  hdr;
  logic        vld;
  logic        first;

  always #5 clk = ~clk;

  rx_gearbox_32b66b dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_data   (din),
    .i_slip   (slip),
    .o_data   (dout),
    .o_header (hdr),
    .o_valid  (vld),
    .o_first  (first)
  );

  typedef struct packed {
    logic        first;
    logic [1:0]  hdr;
    logic [31:0] data;
  } half_t;

  typedef struct packed {
    logic        slip;
    logic        valid;
    logic        first;
    logic [1:0]  hdr;
    logic [31:0] data;
  } vec_t;

  half_t sbq[$];
  bit    bitq[$];
  int    checks = 0;
  int    failures = 0;
  int    nblk;
  bit    fixed_mode;
  bit    sb_push;

  function automatic logic [31:0] lo_of(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    return {16'hC3A5, kk};
  endfunction

  function automatic logic [31:0] hi_of(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    return {~kk, 16'h7E81};
  endfunction

  function automatic logic [1:0] hd_of(input int k);
    return k[0] ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [65:0] blk(input int k);
    if (fixed_mode) return {64'h0123456789ABCDEF, 2'b10};
    return {hi_of(k), lo_of(k), hd_of(k)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic refill();
    logic [65:0] b;
    while (bitq.size() < 32) begin
      b = blk(nblk);
      for (int i = 0; i < 66; i++) bitq.push_back(b[i]);
      if (sb_push) begin
        sbq.push_back({1'b1, b[1:0], b[33:2]});
        sbq.push_back({1'b0, b[1:0], b[65:34]});
      end
      nblk++;
    end
  endtask

  task automatic step(input logic s);
    refill();
    for (int i = 0; i < 32; i++) din[i] = bitq.pop_front();
    slip = s;
    @(posedge clk);
    #1;
    slip = 1'b0;
  endtask

  task automatic sb_check();
    half_t e;
    if (vld) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra: got half %h with nothing expected", {first, hdr, dout});
      end else begin
        e = sbq.pop_front();
        chk("sb_half", {first, hdr, dout}, e);
      end
    end
  endtask

  task automatic start(input int junk, input bit push, input bit fixed);
    rst  = 1'b1;
    slip = 1'b0;
    din  = 32'h0;
    sbq.delete();
    bitq.delete();
    fixed_mode = fixed;
    sb_push    = push;
    nblk       = 1;
    for (int i = 0; i < junk; i++) bitq.push_back(i[0] ^ 1'b1);
    @(posedge clk);
    #1;
    chk("rst_out", {vld, first, hdr, dout}, 64'h0);
    rst = 1'b0;
  endtask

  // Find the next first half, decode its block index and check the stream.
  task automatic sync_check(input string tag);
    bit          found;
    int          k;
    logic [15:0] kk;
    found = 1'b0;
    k = 0;
    for (int c = 0; c < 6 && !found; c++) begin
      step(1'b0);
      if (vld && first) begin
        found = 1'b1;
        kk = dout[15:0];
        k  = int'(kk);
        chk({tag, "_sync"}, {hdr, dout}, {hd_of(k), lo_of(k)});
        sbq.delete();
        sbq.push_back({1'b0, hd_of(k), hi_of(k)});
        for (int j = 1; j <= 12; j++) begin
          sbq.push_back({1'b1, hd_of(k + j), lo_of(k + j)});
          sbq.push_back({1'b0, hd_of(k + j), hi_of(k + j)});
        end
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s_sync: no first half within 6 cycles", tag);
    end else begin
      for (int c = 0; c < 24; c++) begin
        step(1'b0);
        sb_check();
      end
    end
  endtask

  initial begin
    vec_t tab [6];
    int   nvalid;
    int   last_gap;
    bit   seen;
    int   drops;

    tab[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h00000000};
    tab[1] = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h89ABCDEF};
    tab[2] = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h01234567};
    tab[3] = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h89ABCDEF};
    tab[4] = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h01234567};
    tab[5] = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h89ABCDEF};

    rst  = 1'b1;
    slip = 1'b0;
    din  = 32'h0;
    #12;

    // Fixed block pattern, cycle by cycle from reset.
    start(0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(tab[i].slip);
      chk($sformatf("vec%0d", i), {vld, first, hdr, dout},
          {tab[i].valid, tab[i].first, tab[i].hdr, tab[i].data});
    end

    // 330 cycles of indexed blocks: 320 valid halves, gaps 33 cycles apart.
    start(0, 1'b1, 1'b0);
    nvalid = 0;
    last_gap = -1;
    for (int c = 1; c <= 330; c++) begin
      step(1'b0);
      sb_check();
      if (vld) nvalid++;
      else begin
        if (last_gap >= 0) chk("gap_spacing", c - last_gap, 33);
        last_gap = c;
      end
    end
    chk("valid_count", nvalid, 320);

    // Slip on the first cycle after reset drops the single junk bit.
    start(1, 1'b1, 1'b0);
    step(1'b1);
    chk("slip0_novalid", vld, 1'b0);
    for (int c = 0; c < 40; c++) begin
      step(1'b0);
      sb_check();
    end

    // Asynchronous reset while in the second phase, then a fresh start.
    start(0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      step(1'b0);
      sb_check();
      if (vld && first) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL mid_first: no first half within 8 cycles");
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {vld, first, hdr, dout}, 64'h0);
    start(0, 1'b1, 1'b0);
    for (int c = 0; c < 70; c++) begin
      step(1'b0);
      sb_check();
    end

    // Stream offset by 5 bits, corrected by 5 slips 40 cycles apart.
    start(5, 1'b0, 1'b0);
    for (int c = 0; c < 200; c++) step((c % 40 == 10) ? 1'b1 : 1'b0);
    sync_check("offset5");

    // Slip held for 40 cycles.
`ifdef RX_GEARBOX_SLIP_BLANK_EN
    drops = 2;
`else
    drops = 40;
`endif
    start(drops, 1'b0, 1'b0);
    for (int c = 0; c < 40; c++) step(1'b1);
    for (int c = 0; c < 10; c++) step(1'b0);
    sync_check("held_slip");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_gearbox_32b66b.md
# rx_gearbox_32b66b

Internal receive gearbox for the 32-bit PCS datapath. It converts the raw, unframed 32-bit word stream from the transceiver into 64b/66b block halves: 32 data bits plus a 2-bit sync header, with a valid strobe. It also executes single-bit slips requested by the block-lock state machine. It sits between the transceiver RX data output and the descrambler/lock/decoder chain, and takes the place of the transceiver's own gearbox when the PCS is built without an external gearbox.

## Interface
- No parameters. Widths are fixed by package constants: 32-bit words, 66-bit blocks.
- i_clk  in  1  recovered RX clock; all logic runs on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_data  in  32  raw line word; bit 0 is the earliest received bit. Sampled on every edge, with no valid qualifier.
- i_slip  in  1  slip request from lock_state; one asserted cycle discards one bit.
- o_data  out  32  block half: descrambler input.
- o_header  out  2  sync header of the current block; held for both halves.
- o_valid  out  1  o_data and o_header are valid this cycle.
- o_first  out  1  o_data is the first half (block bits 33:2) of its block.

## Operation
- Stored bit buffer `buf[65:0]` with occupancy count `cnt[6:0]`. Bit 0 is the oldest bit.
- Each cycle, form the combined vector `comb = buf | (i_data << cnt)` and set `avail = cnt + 32`.
- Slip accepted this cycle: set `comb = comb >> 1` and `avail = avail - 1`. When `cnt = 0`, this drops `i_data[0]`.
- Phase state machine with states FIRST and SECOND. Reset state is FIRST.
- FIRST, `avail >= 34`:
  - `o_header <= comb[1:0]`, `o_data <= comb[33:2]`, `o_first <= 1`, `o_valid <= 1`.
  - `buf <= comb >> 34`, `cnt <= avail - 34`, next state SECOND.
- SECOND, `avail >= 32`:
  - `o_data <= comb[31:0]`, `o_first <= 0`, `o_valid <= 1`, `o_header` held.
  - `buf <= comb >> 32`, `cnt <= avail - 32`, next state FIRST.
- Otherwise: `o_valid <= 0`, `buf <= comb`, `cnt <= avail`, state unchanged, `o_data`/`o_header`/`o_first` held.
- Bounds: `cnt` never exceeds 33 and `avail` never exceeds 65, so a 66-bit buffer is sufficient. `cnt` stays non-negative under slip because 32 bits are always added.
- Steady state: exactly one `o_valid = 0` cycle per 33 cycles (32 halves = 16 blocks per 1056 input bits).
- A slip taken in SECOND shifts the second half by one bit. Downstream tolerates this because lock is not yet achieved whenever slips occur.

## Timing
- All outputs are registered. Reset values: `o_data = 0`, `o_header = 0`, `o_valid = 0`, `o_first = 0`, `cnt = 0`, state FIRST, `buf = 0`.
- Latency: an input bit appears on `o_data` 1 to 2 edges after it is sampled.
- First `o_valid` occurs after the second sampling edge following reset release.
- `i_slip` takes effect on the edge that samples it. It never stalls or flushes the pipeline.
- Reset asserted mid-operation clears everything immediately. Alignment restarts from bit 0 of the first post-reset word.

## Configuration
- `RX_GEARBOX_SLIP_BLANK_EN` defined:
  - An accepted slip starts a 6-bit blanking counter.
  - `i_slip` is ignored for the next 32 cycles, so a held or repeated request costs one bit per 33 cycles.
- Undefined: every cycle with `i_slip = 1` drops one bit, and no counter is built.

## Structure
- Add `GB_WORD_W = 32`, `GB_HDR_W = 2`, `GB_BLOCK_W = 66`, and `GB_SLIP_BLANK = 32` to `code_defs_pkg`.
- Single module, no sub-modules. The combined-vector shift and extract is a local function.

## Test plan
- Reset, then feed a packed LSB-first stream of blocks `{data = 64'h0123456789ABCDEF, hdr = 2'b10}`:
  - After the 2nd edge: `o_valid = 1`, `o_first = 1`, `o_header = 2'b10`, `o_data = 32'h89ABCDEF`.
  - Next cycle: `o_first = 0`, `o_data = 32'h01234567`.
- Run 330 cycles of continuous blocks -> exactly 320 valid cycles, with gaps spaced 33 cycles apart and every header equal to 2'b10/2'b01 as sent.
- Stream offset by 5 bits, with 5 single-cycle slips spaced 40 cycles apart:
  - Headers alternate 2'b01/2'b10 exactly as sent.
  - Data matches after the 5th slip.
- Slip on the first cycle after reset (`cnt = 0`) -> `i_data[0]` discarded; the next block aligns 1 bit later.
- Assert `i_reset` asynchronously mid-block (state SECOND) -> all outputs 0 before the next edge; realignment matches a fresh start.
- `RX_GEARBOX_SLIP_BLANK_EN` defined, `i_slip` held high for 40 cycles -> exactly 2 bits dropped. Undefined -> 40 bits dropped.
